csr_counters: RTL and testbench
===============================

# csr_counters

Parametrised Zicntr/Zihpm counter bank for the AsteRISC core. It holds mcycle, minstret, and NUM_HPM programmable hardware performance counters (mhpmcounter3..), plus their mhpmevent selectors and mcountinhibit. It serves the core's CSR unit through a one-cycle request/response port and extends the fixed counter address map with configurable counter width and event routing.

## Interface
- XLEN, 32: CSR data width; only 32 is supported.
- NUM_HPM, 4: number of HPM counters, 0..29, mapped as mhpmcounter3..mhpmcounter(3+NUM_HPM-1).
- HPM_WIDTH, 40: implemented HPM counter width, 1..64; unimplemented upper bits read 0.
- NUM_EVENTS, 8: width of the event input bus, 1..31.
- p_clk  in  1  core clock; single clock domain.
- p_reset  in  1  reset, synchronous, active-high.
- csr_req  in  1  CSR access valid this cycle.
- csr_addr  in  12  CSR address.
- csr_op  in  2  access op: 0 read only, 1 write, 2 set, 3 clear.
- csr_wdata  in  XLEN  write/set/clear operand.
- csr_ack  out  1  response valid; exactly one cycle after csr_req.
- csr_rdata  out  XLEN  old CSR value; 0 when csr_illegal is set.
- csr_illegal  out  1  address is not owned by this bank, or is a write to a read-only alias.
- instr_retired  in  1  one-cycle pulse per retired instruction.
- hpm_event  in  NUM_EVENTS  per-cycle event strobes.

## Operation
- Address map:
  - mcycle 0xB00/0xB80 (low/high).
  - minstret 0xB02/0xB82.
  - mhpmcounterN 0xB00+N and 0xB80+N, for N = 3..3+NUM_HPM-1.
  - mhpmeventN 0x320+N.
  - mcountinhibit 0x320.
  - read-only aliases cycle/instret/hpmcounterN at 0xC00+N and 0xC80+N.
  - time/timeh (0xC01/0xC81) are not owned and return illegal.
- mcycle and minstret are 64 bits. mcycle increments every cycle; minstret increments on instr_retired.
- mcountinhibit:
  - bit0 inhibits mcycle, bit2 inhibits minstret, bit N inhibits mhpmcounterN.
  - bit1 and bits above 3+NUM_HPM-1 are hardwired to 0.
- mhpmeventN holds a 5-bit selector; bits above 4 read 0.
  - Value 0 means never count.
  - Value k in 1..NUM_EVENTS means increment when hpm_event[k-1] is high.
  - Values above NUM_EVENTS never count but keep the written value.
- Write data for the accessed register:
  - op 1 writes csr_wdata.
  - op 2 writes old | csr_wdata.
  - op 3 writes old & ~csr_wdata.
  - op 0 writes nothing.
- Access to an alias address:
  - Ops 2/3 with csr_wdata==0 count as reads and are legal.
  - Any other write op is illegal.
- An illegal access changes no state.
- A low-half write replaces bits [31:0] and a high-half write replaces bits [63:32]; the other half is kept.
- Counters wrap silently. mcycle/minstret wrap at 2^64; HPM counters wrap at 2^HPM_WIDTH, and bits written above HPM_WIDTH are dropped.
- When a CSR write hits any half of a counter, that counter's increment is suppressed for that cycle. The written value is what is stored.
- When NUM_HPM=0, all HPM addresses are illegal.

## Timing
- Request at cycle t gives csr_ack, csr_rdata and csr_illegal at t+1, all registered. Reads return the value before any write in cycle t.
- Back-to-back requests are accepted every cycle with no stall.
- State updates land at the edge ending cycle t. A read at t+1 sees the written value; for mcycle it sees the written value + 1 only if not inhibited.
- mcountinhibit written at t takes effect on increments from cycle t+1; the increment in cycle t uses the old inhibit value.
- An event selector written at t applies from t+1.
- Reset values:
  - All counters, selectors and mcountinhibit are 0.
  - csr_ack, csr_rdata and csr_illegal are 0.
- During p_reset no increments occur and any csr_req is dropped with no ack.
- A request in the cycle p_reset deasserts is served normally.
- Simultaneous instr_retired and a minstret write: the write wins.
- Low-half carry into the high half happens in the same cycle as the increment (full-width adder).

## Test plan
- Reset, then hold idle for 10 cycles -> read 0xB00 returns 10 (counting from the first post-reset cycle), csr_ack is high one cycle after csr_req, and 0xB80 returns 0.
- Write 0xB00=0xFFFF_FFFF at cycle t -> read 0xB80 two cycles later returns 1, and 0xB00 returns a small value with no glitch on the carry.
- Write 0x320=0x5, then pulse instr_retired 3 times -> mcycle and minstret are frozen, reads return the pre-write values, csr_illegal=0.
- Set mhpmevent3=2, drive hpm_event[1] for 7 cycles and hpm_event[0] for 4 -> mhpmcounter3 (0xB03) reads 7.
- Write mhpmcounter3 to all-ones with HPM_WIDTH=40, then 1 event -> 0xB03 and 0xB83 read 0 (wrap).
- csr_op=1 to 0xC00, and a read of 0xC01 -> csr_illegal=1, csr_rdata=0, mcycle is unchanged apart from normal counting.

Source files
------------

// File: rtl/csr_counters_if.sv
// CSR request/response port between the core's CSR unit and the counter bank.
interface csr_counters_if #(
    parameter int unsigned XLEN = 32
);
    logic            csr_req;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_ack;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_req, csr_addr, csr_op, csr_wdata,
        input  csr_ack, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_req, csr_addr, csr_op, csr_wdata,
        output csr_ack, csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counters.sv
// Zicntr/Zihpm counter bank: mcycle, minstret, NUM_HPM programmable HPM counters,
// their event selectors and mcountinhibit, behind a one-cycle CSR port.
module csr_counters #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned HPM_WIDTH  = 40,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  p_clk,
    input  logic                  p_reset,
    csr_counters_if.slave         csr,
    input  logic                  instr_retired,
    input  logic [NUM_EVENTS-1:0] hpm_event
);
    // Keep arrays non-empty when no HPM counters are implemented.
    localparam int unsigned HpmN        = (NUM_HPM == 0) ? 1 : NUM_HPM;
    localparam logic [63:0] HpmBits     = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] InhibitMask = HpmBits[31:0] | 32'h0000_0005;

    function automatic logic [63:0] merge_half(input logic [63:0] old, input logic hi,
                                               input logic [31:0] val);
        return hi ? {val, old[31:0]} : {old[63:32], val};
    endfunction

    logic [63:0]          mcycle_q, mcycle_d;
    logic [63:0]          minstret_q, minstret_d;
    logic [HPM_WIDTH-1:0] hpm_q [HpmN];
    logic [HPM_WIDTH-1:0] hpm_d [HpmN];
    logic [4:0]           sel_q [HpmN];
    logic [4:0]           sel_d [HpmN];
    logic [31:0]          inhibit_q, inhibit_d;
    logic                 ack_q, illegal_q;
    logic [XLEN-1:0]      rdata_q;

    logic [4:0]      idx;
    logic            hi, is_cnt_m, is_cnt_a, is_cfg;
    logic            owned, illegal, do_write;
    logic [63:0]     cnt64;
    logic [XLEN-1:0] old_val, new_val;
    logic            ev_hit [HpmN];

    assign idx      = csr.csr_addr[4:0];
    assign hi       = csr.csr_addr[7];
    assign is_cnt_m = (csr.csr_addr[11:8] == 4'hB) && (csr.csr_addr[6:5] == 2'b00);
    assign is_cnt_a = (csr.csr_addr[11:8] == 4'hC) && (csr.csr_addr[6:5] == 2'b00);
    assign is_cfg   = (csr.csr_addr[11:5] == 7'h19);

    // Address ownership and old-value read mux
    always_comb begin
        owned   = 1'b0;
        cnt64   = '0;
        old_val = '0;
        if (is_cnt_m || is_cnt_a) begin
            if (idx == 5'd0) begin
                owned = 1'b1;
                cnt64 = mcycle_q;
            end else if (idx == 5'd2) begin
                owned = 1'b1;
                cnt64 = minstret_q;
            end
            for (int unsigned i = 0; i < NUM_HPM; i++) begin
                if (32'(idx) == i + 3) begin
                    owned = 1'b1;
                    cnt64 = 64'(hpm_q[i]);
                end
            end
            old_val = hi ? cnt64[63:32] : cnt64[31:0];
        end else if (is_cfg) begin
            if (idx == 5'd0) begin
                owned   = 1'b1;
                old_val = inhibit_q;
            end
            for (int unsigned i = 0; i < NUM_HPM; i++) begin
                if (32'(idx) == i + 3) begin
                    owned   = 1'b1;
                    old_val = {27'd0, sel_q[i]};
                end
            end
        end
    end

    // Legality and write-data generation; set/clear of zero on an alias is a plain read
    always_comb begin
        illegal  = !owned ||
                   (is_cnt_a && ((csr.csr_op == 2'd1) ||
                                 ((csr.csr_op != 2'd0) && (csr.csr_wdata != '0))));
        do_write = csr.csr_req && !illegal && (csr.csr_op != 2'd0) && !is_cnt_a;
        unique case (csr.csr_op)
            2'd1:    new_val = csr.csr_wdata;
            2'd2:    new_val = old_val | csr.csr_wdata;
            2'd3:    new_val = old_val & ~csr.csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // Per-counter event match; selectors outside 1..NUM_EVENTS never match
    always_comb begin
        for (int unsigned i = 0; i < HpmN; i++) begin
            ev_hit[i] = 1'b0;
            for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
                if ((32'(sel_q[i]) == e + 1) && hpm_event[e]) ev_hit[i] = 1'b1;
            end
        end
    end

    // Counter/config next state: a write to either half suppresses that counter's increment
    always_comb begin
        mcycle_d   = mcycle_q;
        minstret_d = minstret_q;
        hpm_d      = hpm_q;
        sel_d      = sel_q;
        inhibit_d  = inhibit_q;

        if (do_write && is_cnt_m && (idx == 5'd0)) begin
            mcycle_d = merge_half(mcycle_q, hi, new_val);
        end else if (!inhibit_q[0]) begin
            mcycle_d = mcycle_q + 64'd1;
        end

        if (do_write && is_cnt_m && (idx == 5'd2)) begin
            minstret_d = merge_half(minstret_q, hi, new_val);
        end else if (!inhibit_q[2] && instr_retired) begin
            minstret_d = minstret_q + 64'd1;
        end

        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (do_write && is_cnt_m && (32'(idx) == i + 3)) begin
                hpm_d[i] = HPM_WIDTH'(merge_half(64'(hpm_q[i]), hi, new_val));
            end else if (!inhibit_q[i+3] && ev_hit[i]) begin
                hpm_d[i] = hpm_q[i] + HPM_WIDTH'(1);
            end
            if (do_write && is_cfg && (32'(idx) == i + 3)) sel_d[i] = new_val[4:0];
        end

        if (do_write && is_cfg && (idx == 5'd0)) inhibit_d = new_val & InhibitMask;
    end

    // State registers and registered CSR response
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inhibit_q  <= '0;
            for (int unsigned i = 0; i < HpmN; i++) begin
                hpm_q[i] <= '0;
                sel_q[i] <= '0;
            end
            ack_q      <= 1'b0;
            illegal_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            inhibit_q  <= inhibit_d;
            hpm_q      <= hpm_d;
            sel_q      <= sel_d;
            ack_q      <= csr.csr_req;
            if (csr.csr_req) begin
                illegal_q <= illegal;
                rdata_q   <= illegal ? '0 : old_val;
            end
        end
    end

    assign csr.csr_ack     = ack_q;
    assign csr.csr_rdata   = rdata_q;
    assign csr.csr_illegal = illegal_q;
endmodule

// File: tb/tb_csr_counters.sv
// Directed bench for csr_counters: stimulus pushes expected responses, a monitor checks acks.
module tb_csr_counters;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_HPM    = 4;
    localparam int unsigned HPM_WIDTH  = 40;
    localparam int unsigned NUM_EVENTS = 8;

    typedef struct {
        string       name;
        logic        ill;
        logic [31:0] rd;
    } exp_t;

    logic                  p_clk = 1'b0;
    logic                  p_reset;
    logic                  instr_retired;
    logic [NUM_EVENTS-1:0] hpm_event;
    logic                  req_prev = 1'b0;
    exp_t                  exp_q [$];
    exp_t                  mon_e;
    int                    total = 0;
    int                    bad   = 0;

    csr_counters_if #(.XLEN(XLEN)) bus ();

    csr_counters #(
        .XLEN      (XLEN),
        .NUM_HPM   (NUM_HPM),
        .HPM_WIDTH (HPM_WIDTH),
        .NUM_EVENTS(NUM_EVENTS)
    ) dut (
        .p_clk        (p_clk),
        .p_reset      (p_reset),
        .csr          (bus),
        .instr_retired(instr_retired),
        .hpm_event    (hpm_event)
    );

    always #5 p_clk = ~p_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // One request in the current cycle; expected response queued for the monitor.
    task automatic req(input string name, input logic [11:0] addr, input logic [1:0] op,
                       input logic [31:0] wd, input logic ill, input logic [31:0] rd);
        exp_t e;
        e.name = name;
        e.ill  = ill;
        e.rd   = rd;
        exp_q.push_back(e);
        bus.csr_req   = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        @(posedge p_clk);
        #1;
        bus.csr_req   = 1'b0;
        bus.csr_op    = 2'd0;
        bus.csr_wdata = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge p_clk);
            #1;
        end
    endtask

    // Track whether an accepted request should be answered this cycle
    always @(posedge p_clk) req_prev <= bus.csr_req && !p_reset;

    // Monitor: ack timing plus scoreboard pop on every ack
    always @(negedge p_clk) begin
        if (bus.csr_ack || req_prev) check("ack_timing", {31'd0, bus.csr_ack}, {31'd0, req_prev});
        if (bus.csr_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with nothing outstanding, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_illegal"}, {31'd0, bus.csr_illegal}, {31'd0, mon_e.ill});
                check({mon_e.name, "_rdata"}, bus.csr_rdata, mon_e.rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        p_reset       = 1'b1;
        bus.csr_req   = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_op    = 2'd0;
        bus.csr_wdata = '0;
        instr_retired = 1'b0;
        hpm_event     = '0;
        repeat (2) @(posedge p_clk);
        #1;
        // Request during reset must be dropped
        bus.csr_req  = 1'b1;
        bus.csr_addr = 12'hB00;
        @(posedge p_clk);
        #1;
        bus.csr_req = 1'b0;
        @(negedge p_clk);
        check("reset_ack", {31'd0, bus.csr_ack}, 32'd0);
        check("reset_rdata", bus.csr_rdata, 32'd0);
        check("reset_illegal", {31'd0, bus.csr_illegal}, 32'd0);
        @(posedge p_clk);
        #1;
        p_reset = 1'b0;

        idle(10);
        req("mcycle_after_reset", 12'hB00, 2'd0, 32'd0, 1'b0, 32'd10);
        req("mcycleh_after_reset", 12'hB80, 2'd0, 32'd0, 1'b0, 32'd0);
        req("mcycle_write", 12'hB00, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'd12);
        req("mcycle_written", 12'hB00, 2'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        req("mcycleh_carry", 12'hB80, 2'd0, 32'd0, 1'b0, 32'd1);
        req("mcycle_post_carry", 12'hB00, 2'd0, 32'd0, 1'b0, 32'd1);

        instr_retired = 1'b1;
        idle(2);
        instr_retired = 1'b0;
        req("minstret_two", 12'hB02, 2'd0, 32'd0, 1'b0, 32'd2);

        req("inhibit_write", 12'h320, 2'd1, 32'h5, 1'b0, 32'd0);
        instr_retired = 1'b1;
        idle(3);
        instr_retired = 1'b0;
        req("mcycle_frozen", 12'hB00, 2'd0, 32'd0, 1'b0, 32'd6);
        req("minstret_frozen", 12'hB02, 2'd0, 32'd0, 1'b0, 32'd2);
        req("mcycleh_frozen", 12'hB80, 2'd0, 32'd0, 1'b0, 32'd1);

        req("event3_write", 12'h323, 2'd1, 32'd2, 1'b0, 32'd0);
        hpm_event = 8'h02;
        idle(7);
        hpm_event = 8'h01;
        idle(4);
        hpm_event = 8'h00;
        req("hpm3_count", 12'hB03, 2'd0, 32'd0, 1'b0, 32'd7);
        req("event3_read", 12'h323, 2'd0, 32'd0, 1'b0, 32'd2);
        req("event4_write", 12'h324, 2'd1, 32'h3F, 1'b0, 32'd0);
        req("event4_masked", 12'h324, 2'd0, 32'd0, 1'b0, 32'h1F);

        req("hpm3_lo_write", 12'hB03, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'd7);
        req("hpm3_hi_write", 12'hB83, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        req("hpm3_hi_trunc", 12'hB83, 2'd0, 32'd0, 1'b0, 32'hFF);
        hpm_event = 8'h02;
        req("hpm3_lo_ones", 12'hB03, 2'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        hpm_event = 8'h00;
        req("hpm3_lo_wrap", 12'hB03, 2'd0, 32'd0, 1'b0, 32'd0);
        req("hpm3_hi_wrap", 12'hB83, 2'd0, 32'd0, 1'b0, 32'd0);

        req("alias_write", 12'hC00, 2'd1, 32'h1234, 1'b1, 32'd0);
        req("time_read", 12'hC01, 2'd0, 32'd0, 1'b1, 32'd0);
        req("cycle_alias", 12'hC00, 2'd0, 32'd0, 1'b0, 32'd6);
        req("cycleh_set0", 12'hC80, 2'd2, 32'd0, 1'b0, 32'd1);
        req("instret_clr", 12'hC02, 2'd3, 32'd5, 1'b1, 32'd0);
        req("mcycle_unchanged", 12'hB00, 2'd0, 32'd0, 1'b0, 32'd6);

        req("inhibit_set_all", 12'h320, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'h5);
        req("inhibit_mask", 12'h320, 2'd0, 32'd0, 1'b0, 32'h7D);
        req("inhibit_clear", 12'h320, 2'd3, 32'h7D, 1'b0, 32'h7D);
        idle(1);
        req("mcycle_resumed", 12'hB00, 2'd0, 32'd0, 1'b0, 32'd7);
        req("hpm7_absent", 12'hB07, 2'd0, 32'd0, 1'b1, 32'd0);
        req("cfg321_absent", 12'h321, 2'd0, 32'd0, 1'b1, 32'd0);
        req("b01_write", 12'hB01, 2'd1, 32'h55, 1'b1, 32'd0);

        instr_retired = 1'b1;
        req("minstret_write", 12'hB02, 2'd1, 32'd100, 1'b0, 32'd2);
        instr_retired = 1'b0;
        req("minstret_write_wins", 12'hB02, 2'd0, 32'd0, 1'b0, 32'd100);
        req("hpm4_sel_out_of_range", 12'hB04, 2'd0, 32'd0, 1'b0, 32'd0);

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
